// File: rtl/multiword_adder_seq_pkg.sv
// multiword_adder_pkg: shared state encoding and default sizes for the wide adder
package multiword_adder_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_WORDS = 4;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/multiword_adder_seq_adder.sv
// adder_behavior: W-bit combinational add with carry-in and carry-out
module adder_behavior #(
    parameter int W = 32
) (
    output logic [W-1:0] s,
    output logic         co,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: word-serial wide adder driving one combinational adder per cycle
module multiword_adder_seq
    import multiword_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] a_in,
    input  logic [WIDTH*WORDS-1:0] b_in,
    input  logic                   ci_in,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] sum_out,
    output logic                   co_out
);
    localparam int N  = WIDTH * WORDS;
    localparam int IW = $clog2(WORDS);
    logic [1:0]       state;
    logic [N-1:0]     a_r, b_r;
    logic [IW-1:0]    idx;
    logic             carry, co;
    logic [WIDTH-1:0] s;
    logic             last;
    adder_behavior #(.W(WIDTH)) u_add (
        .s  (s),
        .co (co),
        .a  (a_r[idx*WIDTH +: WIDTH]),
        .b  (b_r[idx*WIDTH +: WIDTH]),
        .ci (carry)
    );
    assign last = idx == IW'(WORDS - 1);
    assign busy = state == RUN || state == DONE;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            sum_out <= '0;
            co_out  <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_r     <= a_in;
                b_r     <= b_in;
                carry   <= ci_in;
                idx     <= '0;
                sum_out <= '0;
                co_out  <= 1'b0;
                state   <= RUN;
            end
        end else if (state == RUN) begin
            sum_out[idx*WIDTH +: WIDTH] <= s;
            carry <= co;
            if (last) begin
                co_out <= co;
                state  <= DONE;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_multiword_adder_seq.sv
// tb_multiword_adder_seq: directed and random checks against a cycle-count arithmetic model
module tb_multiword_adder_seq;
    localparam int WIDTH = 32;
    localparam int WORDS = 4;
    localparam int N = WIDTH * WORDS;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
    logic         ci_in = 1'b0;
    logic         busy, done, co_out;
    logic [N-1:0] sum_out;
    int checks = 0;
    int errors = 0;

    multiword_adder_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .ci_in(ci_in), .busy(busy), .done(done), .sum_out(sum_out), .co_out(co_out)
    );

    always #5 clk = ~clk;

    // model: cycles remaining until idle, the pending exact sum, and the visible result
    int         m_cnt;
    logic [N:0] m_exp, m_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_exp <= '0;
            m_res <= '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt <= WORDS + 1;
                m_exp <= {1'b0, a_in} + {1'b0, b_in} + (N+1)'(ci_in);
                m_res <= '0;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_res <= m_exp;
        end
    end

    task automatic chk(input string nm, input logic [N:0] got, input logic [N:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", (N+1)'(busy), (N+1)'(m_cnt != 0));
            chk("done", (N+1)'(done), (N+1)'(m_cnt == 1));
            if (m_cnt <= 1) chk("result", {co_out, sum_out}, m_res);
            else chk("co_run", (N+1)'(co_out), '0);
        end
    end

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                          output logic [N:0] res, output int lat);
        @(negedge clk);
        a_in = a; b_in = b; ci_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout waiting for done");
        end
        res = {co_out, sum_out};
        @(negedge clk);
        chk("done_one_cycle", (N+1)'(done), '0);
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, "_busy"}, (N+1)'(busy), '0);
        chk({nm, "_done"}, (N+1)'(done), '0);
        chk({nm, "_sum"}, (N+1)'(sum_out), '0);
        chk({nm, "_co"}, (N+1)'(co_out), '0);
    endtask

    task automatic abort_at(input int k, input string nm);
        int seen;
        @(negedge clk);
        a_in = {4{32'hDEADBEEF}}; b_in = {4{32'h12345678}}; ci_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b1;
        #1;
        check_cleared(nm);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_cleared({nm, "_post"});
        chk({nm, "_no_done"}, (N+1)'(seen), '0);
    endtask

    logic [N:0]   res, r1;
    logic [N-1:0] ra, rb;
    logic         rc;
    int           lat, gap, idle_cycles;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_cleared("reset");
        abort_at(1, "rst_mid");

        run_op({4{32'hFFFFFFFF}}, 128'h1, 1'b0, res, lat);
        chk("ripple", res, {1'b1, 128'h0});
        chk("ripple_latency", (N+1)'(lat), (N+1)'(WORDS));

        run_op('0, '0, 1'b1, res, lat);
        chk("carry_in", res, 129'h1);

        run_op(128'h00000001_00000002_00000003_00000004,
               128'h00000010_00000020_00000030_00000040, 1'b0, res, lat);
        chk("words", res, 129'h00000011_00000022_00000033_00000044);

        // start held high throughout; a_in changes while the first add runs
        @(negedge clk);
        a_in = 128'h5; b_in = 128'h7; ci_in = 1'b0; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_in = 128'h100;
        lat = 0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        r1 = {co_out, sum_out};
        chk("held_first", r1, 129'hC);
        gap = 0; idle_cycles = 0;
        do begin
            @(negedge clk);
            gap++;
            if (!busy) idle_cycles++;
        end while (!done && gap < 20);
        chk("held_second", {co_out, sum_out}, 129'h107);
        chk("held_period", (N+1)'(gap), (N+1)'(WORDS + 2));
        chk("held_idle", (N+1)'(idle_cycles), 129'h1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        abort_at(2, "abort");

        for (int i = 0; i < 100; i++) begin
            ra = {$random, $random, $random, $random};
            rb = {$random, $random, $random, $random};
            rc = 1'($random);
            run_op(ra, rb, rc, res, lat);
            chk("random", res, {1'b0, ra} + {1'b0, rb} + (N+1)'(rc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
